// File: rtl/pipe_reg_chain_if.sv
// Handshake bundle for pipe_reg_chain: upstream valid/ready/data, downstream
// valid/ready/data, and the live occupancy count.
interface pipe_reg_chain_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  localparam int OW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OW-1:0]    occupancy;

  // The pipeline itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

  // Whoever feeds the pipeline and consumes its output.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage register pipeline with valid/ready flow control.
// Empty stages never block the stages behind them, so words pack towards the
// output under backpressure and full throughput is kept when out_ready is high.
// The ready path is purely combinational from the output stage back to the input.
module pipe_reg_chain #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  pipe_reg_chain_if.slave bus
);
  localparam int OW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [OW-1:0]    r_occ;

  logic [DEPTH-1:0] w_adv;
  logic             w_in_ready;
  logic             w_acc;
  logic             w_emit;

  // Advance chain, walked from the output stage towards the input stage.
  // clr kills the output handshake, which stalls the whole chain for that cycle.
  always_comb begin
    logic w_up;
    w_adv          = '0;
    w_up           = r_v[DEPTH-1] & bus.out_ready & ~clr;
    w_adv[DEPTH-1] = w_up;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_up     = r_v[i] & (~r_v[i+1] | w_up);
      w_adv[i] = w_up;
    end
  end

  // Input is held off while reset is asserted even though the stages are
  // already cleared, so nothing looks accepted before release.
  assign w_in_ready = reset & ~clr & (~r_v[0] | w_adv[0]);
  assign w_acc      = bus.in_valid & w_in_ready;
  assign w_emit     = w_adv[DEPTH-1];

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_v[DEPTH-1] & ~clr;
  assign bus.out_data  = r_d[DEPTH-1];
  assign bus.occupancy = r_occ;

  // Stage registers: async reset and sync flush restore RESET_VAL; otherwise
  // each stage loads from the one behind it on advance, or drops its valid bit
  // when it hands its word on without receiving a new one. Data of a stage
  // that empties is left alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v   <= '0;
      r_occ <= '0;
      for (int i = 0; i < DEPTH; i++) r_d[i] <= RESET_VAL;
    end else if (clr) begin
      r_v   <= '0;
      r_occ <= '0;
      for (int i = 0; i < DEPTH; i++) r_d[i] <= RESET_VAL;
    end else begin
      if (w_acc) begin
        r_v[0] <= 1'b1;
        r_d[0] <= bus.in_data;
      end else if (w_adv[0]) begin
        r_v[0] <= 1'b0;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_adv[i-1]) begin
          r_v[i] <= 1'b1;
          r_d[i] <= r_d[i-1];
        end else if (w_adv[i]) begin
          r_v[i] <= 1'b0;
        end
      end
      r_occ <= r_occ + OW'(w_acc) - OW'(w_emit);
    end
  end
endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain (WIDTH=8, DEPTH=3, non-zero RESET_VAL).
// Reference model: a queue of in-flight words, each tagged with its stage
// position; a word moves up one stage per cycle unless the word ahead of it
// still occupies the stage it would move into.
module tb_pipe_reg_chain;
  localparam int         W  = 8;
  localparam int         D  = 3;
  localparam int         OW = $clog2(D + 1);
  localparam logic [7:0] RV = 8'h5C;

  logic clk;
  logic reset;
  logic clr;

  pipe_reg_chain_if #(.WIDTH(W), .DEPTH(D)) bus ();

  pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q_data [$];
  int         q_pos  [$];

  function automatic bit m_in_ready();
    return (reset === 1'b1) && !clr && ((q_data.size() < D) || bus.out_ready);
  endfunction

  function automatic bit m_out_valid();
    return !clr && (q_data.size() > 0) && (q_pos[0] == D - 1);
  endfunction

  task automatic m_clear();
    q_data.delete();
    q_pos.delete();
  endtask

  task automatic m_edge(input bit acc, input bit emit, input bit c, input logic [7:0] din);
    int lim;
    int np;
    if (c) begin
      m_clear();
      return;
    end
    if (emit) begin
      void'(q_data.pop_front());
      void'(q_pos.pop_front());
    end
    lim = D;
    for (int i = 0; i < q_pos.size(); i++) begin
      np = q_pos[i] + 1;
      if (np > lim - 1) np = lim - 1;
      q_pos[i] = np;
      lim = np;
    end
    if (acc) begin
      q_data.push_back(din);
      q_pos.push_back(0);
    end
  endtask

  // One clock: capture the handshake the model expects, take the edge, update.
  task automatic cycle();
    bit         acc, emit, c;
    logic [7:0] d;
    acc  = bus.in_valid && m_in_ready();
    emit = m_out_valid() && bus.out_ready;
    c    = clr;
    d    = bus.in_data;
    @(posedge clk);
    m_edge(acc, emit, c, d);
    #1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (D + 2) cycle();
  endtask

  task automatic test_reset();
    reset = 1'b0; clr = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.out_ready = 1'b1;
    m_clear();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.occupancy !== OW'(0)) begin n_bad++; $display("FAIL reset_occ: got %0d want 0", bus.occupancy); end
    n_cmp++; if (bus.out_data !== RV) begin n_bad++; $display("FAIL reset_out_data: got %h want %h", bus.out_data, RV); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
    cycle();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #1;
    n_cmp++; if (bus.occupancy !== OW'(1)) begin n_bad++; $display("FAIL release_accept_occ: got %0d want 1", bus.occupancy); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL release_early_valid: got %b want 0", bus.out_valid); end
    cycle();
    cycle();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
      n_bad++; $display("FAIL release_first_word: got v=%b d=%h want v=1 d=a5", bus.out_valid, bus.out_data);
    end
    drain();
    n_cmp++; if (bus.occupancy !== OW'(0)) begin n_bad++; $display("FAIL release_drain_occ: got %0d want 0", bus.occupancy); end
  endtask

  task automatic test_streaming();
    int         got_t [$];
    logic [7:0] got_d [$];
    bus.out_ready = 1'b1;
    for (int t = 0; t < 22; t++) begin
      bus.in_valid = (t < 16);
      bus.in_data  = 8'(t + 1);
      #1;
      if (t < 16) begin
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready t=%0d: got %b want 1", t, bus.in_ready); end
      end
      if (bus.out_valid === 1'b1) begin
        got_t.push_back(t);
        got_d.push_back(bus.out_data);
      end
      cycle();
    end
    n_cmp++; if (got_d.size() != 16) begin n_bad++; $display("FAIL stream_count: got %0d want 16", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 16; i++) begin
      n_cmp++; if (got_d[i] !== 8'(i + 1) || got_t[i] != i + D) begin
        n_bad++; $display("FAIL stream_word%0d: got d=%h at cycle %0d want d=%h at cycle %0d", i, got_d[i], got_t[i], 8'(i + 1), i + D);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [7:0] got_d [$];
    bit         exp_rdy;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h31 + 8'(k);
      #1;
      exp_rdy = (k < 3);
      n_cmp++; if (bus.in_ready !== exp_rdy) begin n_bad++; $display("FAIL bp_in_ready k=%0d: got %b want %b", k, bus.in_ready, exp_rdy); end
      cycle();
    end
    bus.in_valid = 1'b0;
    #1;
    n_cmp++; if (bus.occupancy !== OW'(3)) begin n_bad++; $display("FAIL bp_full_occ: got %0d want 3", bus.occupancy); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_in_ready: got %b want 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h34;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready: got %b want 1", bus.in_ready); end
    for (int t = 0; t < 6; t++) begin
      if (bus.out_valid === 1'b1) got_d.push_back(bus.out_data);
      cycle();
      bus.in_valid = 1'b0;
      #1;
    end
    n_cmp++; if (got_d.size() != 4) begin n_bad++; $display("FAIL bp_drain_count: got %0d want 4", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 4; i++) begin
      n_cmp++; if (got_d[i] !== 8'h31 + 8'(i)) begin n_bad++; $display("FAIL bp_order%0d: got %h want %h", i, got_d[i], 8'h31 + 8'(i)); end
    end
    drain();
  endtask

  task automatic test_bubble();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h11; cycle();
    bus.in_valid = 1'b0; cycle(); cycle();
    bus.in_valid = 1'b1; bus.in_data = 8'h22; cycle();
    bus.in_valid = 1'b0; cycle();
    n_cmp++; if (bus.occupancy !== OW'(2)) begin n_bad++; $display("FAIL bubble_occ: got %0d want 2", bus.occupancy); end
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11) begin
      n_bad++; $display("FAIL bubble_head: got v=%b d=%h want v=1 d=11", bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1'b1; cycle();
    bus.out_ready = 1'b0; #1;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h22) begin
      n_bad++; $display("FAIL bubble_packed: got v=%b d=%h want v=1 d=22", bus.out_valid, bus.out_data);
    end
    drain();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'hC0 + 8'(k); cycle();
    end
    bus.in_valid = 1'b0;
    #1;
    n_cmp++; if (bus.occupancy !== OW'(3)) begin n_bad++; $display("FAIL flush_pre_occ: got %0d want 3", bus.occupancy); end
    clr = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hEE; bus.out_ready = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %b want 0", bus.out_valid); end
    cycle();
    clr = 1'b0; bus.in_valid = 1'b0;
    #1;
    n_cmp++; if (bus.occupancy !== OW'(0)) begin n_bad++; $display("FAIL flush_occ: got %0d want 0", bus.occupancy); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_post_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== RV) begin n_bad++; $display("FAIL flush_out_data: got %h want %h", bus.out_data, RV); end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h77; cycle();
    bus.in_data = 8'h78; cycle();
    #2;
    reset = 1'b0;
    #1;
    m_clear();
    n_cmp++; if (bus.occupancy !== OW'(0) || bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL midreset_async: got occ=%0d v=%b want occ=0 v=0", bus.occupancy, bus.out_valid);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    #1;
  endtask

  task automatic test_random();
    int shown;
    shown = 0;
    for (int t = 0; t < 10000; t++) begin
      bus.in_valid  = ($urandom_range(0, 99) < 60);
      bus.out_ready = ($urandom_range(0, 99) < 55);
      bus.in_data   = 8'($urandom);
      clr           = ($urandom_range(0, 199) == 0);
      #1;
      n_cmp++; if (bus.in_ready !== m_in_ready()) begin
        n_bad++; if (shown++ < 20) $display("FAIL rand_in_ready t=%0d: got %b want %b", t, bus.in_ready, m_in_ready());
      end
      n_cmp++; if (bus.out_valid !== m_out_valid()) begin
        n_bad++; if (shown++ < 20) $display("FAIL rand_out_valid t=%0d: got %b want %b", t, bus.out_valid, m_out_valid());
      end
      n_cmp++; if (bus.occupancy !== OW'(q_data.size())) begin
        n_bad++; if (shown++ < 20) $display("FAIL rand_occ t=%0d: got %0d want %0d", t, bus.occupancy, q_data.size());
      end
      if (m_out_valid()) begin
        n_cmp++; if (bus.out_data !== q_data[0]) begin
          n_bad++; if (shown++ < 20) $display("FAIL rand_data t=%0d: got %h want %h", t, bus.out_data, q_data[0]);
        end
      end
      cycle();
    end
    clr = 1'b0;
    drain();
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
